// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - op codes, FSM encoding and helpers shared by the ALU share arbiter
// Purpose : common definitions for alu_share_arbiter and rr_pick.
// Contents: ALU op codes (OP_AND..OP_SLT, OP_ILL), FSM state enum, index-width helper.
package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Width of a requester index; never below 1 so a single-bit select stays legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker for the ALU share arbiter
// Purpose : choose the first asserted request at or after ptr, wrapping at NUM_REQ.
// Ports   :
//   req   in  NUM_REQ  request vector
//   ptr   in  IW       highest-priority requester index this round
//   grant out NUM_REQ  one-hot grant (all zero when no request)
//   idx   out IW       index of the granted requester (0 when none)
//   any   out 1        at least one request asserted
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    // Walk the requesters in priority order ptr, ptr+1, ... with wrap-around;
    // the first asserted one wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between NUM_REQ requesters
// Purpose : round-robin arbitration of {op,a,b} requests onto an external ALU,
//           returning a registered result per requester (IDLE -> EXEC -> RESP).
// Optional: macro ALU_ARB_OVF_EN adds resp_ovf (signed overflow for add/sub).
// Ports   :
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (ready is a one-cycle accept pulse)
//   req_op/req_a/req_b      packed per-requester op (3 bits) and operands (DW bits)
//   resp_valid/resp_ready   per-requester response handshake (valid is one-hot)
//   resp_result/zero/err    captured result, result==0 flag, illegal-op flag
//   resp_ovf                signed overflow flag (ALU_ARB_OVF_EN only)
//   alu_op/alu_a/alu_b      drive the external ALU (zero outside EXEC)
//   alu_result              combinational ALU output
//   busy                    transaction in progress (state != IDLE)
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_op,
  input  logic [DW*NUM_REQ-1:0] req_a,
  input  logic [DW*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [DW-1:0]         resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
`ifdef ALU_ARB_OVF_EN
  output logic                  resp_ovf,
`endif
  output logic [2:0]            alu_op,
  output logic [DW-1:0]         alu_a,
  output logic [DW-1:0]         alu_b,
  input  logic [DW-1:0]         alu_result,
  output logic                  busy
);

  localparam int IW = idx_w(NUM_REQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
`ifdef ALU_ARB_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // State and datapath registers. Reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_ARB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_ARB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next state and datapath capture.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifdef ALU_ARB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_EXEC;
          win_d   = pick_idx;
          op_d    = req_op[3*int'(pick_idx) +: 3];
          a_d     = req_a[DW*int'(pick_idx) +: DW];
          b_d     = req_b[DW*int'(pick_idx) +: DW];
        end
      end
      S_EXEC: begin
        // An illegal op must not leak whatever the ALU produces for it.
        result_d = (op_q == OP_ILL) ? '0 : alu_result;
        zero_d   = (result_d == '0);
        err_d    = (op_q == OP_ILL);
`ifdef ALU_ARB_OVF_EN
        ovf_d = 1'b0;
        if (op_q == OP_ADD)
          ovf_d = (a_q[DW-1] == b_q[DW-1]) && (alu_result[DW-1] != a_q[DW-1]);
        else if (op_q == OP_SUB)
          ovf_d = (a_q[DW-1] != b_q[DW-1]) && (alu_result[DW-1] != a_q[DW-1]);
`endif
        state_d = S_RESP;
      end
      S_RESP: begin
        // Only the winner's resp_ready matters; priority moves past the winner.
        if (resp_ready[win_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready   = '0;
    resp_valid  = '0;
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;
    busy        = (state_q != S_IDLE);
    resp_result = result_q;
    resp_zero   = zero_q;
    resp_err    = err_q;
`ifdef ALU_ARB_OVF_EN
    resp_ovf    = ovf_q;
`endif
    if (state_q == S_IDLE) req_ready = pick_grant;
    if (state_q == S_EXEC) begin
      alu_op = op_q;
      alu_a  = a_q;
      alu_b  = b_q;
    end
    for (int i = 0; i < NUM_REQ; i++)
      resp_valid[i] = (state_q == S_RESP) && (win_q == IW'(i));
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter (optional ALU_ARB_OVF_EN)
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [3*N-1:0]  req_op;
  logic [DW*N-1:0] req_a, req_b;
  logic [DW-1:0]   resp_result, alu_a, alu_b, alu_result;
  logic            resp_zero, resp_err, busy;
  logic [2:0]      alu_op;
`ifdef ALU_ARB_OVF_EN
  logic            resp_ovf;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
`ifdef ALU_ARB_OVF_EN
    .resp_ovf    (resp_ovf),
`endif
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  // External ALU; the illegal op returns junk so result masking is visible.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a, b, res;
    logic          zero, err, ovf;
  } vec_t;

  typedef struct {
    int            tag;
    int            who;
    logic [DW-1:0] res;
    logic          zero, err, ovf;
  } exp_t;

  exp_t sb[$];
  exp_t exp_next[N];
  int   grant_log[$];
  int   acc_cyc[$];
  int   acc_count = 0;
  int   resp_cyc  = 0;
  int   cyc       = 0;
  int   errors    = 0;
  int   checks    = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input int tag, input logic [DW-1:0] res, input logic zero,
                              input logic err, input logic ovf);
    exp_t e;
    e.tag = tag; e.who = 0; e.res = res; e.zero = zero; e.err = err; e.ovf = ovf;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accepts push the pending expectation, response handshakes pop and compare.
  always @(negedge clk) begin
    int   w;
    exp_t e;
    w = 0;
    if (req_ready != '0) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
      chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
      chk("req_ready_without_valid", 64'(req_valid[w]), 64'd1);
      grant_log.push_back(w);
      acc_cyc.push_back(cyc);
      acc_count++;
      e = exp_next[w];
      e.who = w;
      sb.push_back(e);
    end
    if ((resp_valid & resp_ready) != '0) begin
      for (int i = 0; i < N; i++) if (resp_valid[i]) w = i;
      chk("resp_valid_onehot", 64'($onehot(resp_valid)), 64'd1);
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("t%0d_resp_who", e.tag), 64'(w), 64'(e.who));
        chk($sformatf("t%0d_resp_result", e.tag), 64'(resp_result), 64'(e.res));
        chk($sformatf("t%0d_resp_zero", e.tag), 64'(resp_zero), 64'(e.zero));
        chk($sformatf("t%0d_resp_err", e.tag), 64'(resp_err), 64'(e.err));
`ifdef ALU_ARB_OVF_EN
        chk($sformatf("t%0d_resp_ovf", e.tag), 64'(resp_ovf), 64'(e.ovf));
`endif
      end
      resp_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int n, input string name);
    int t = 0;
    while (acc_count < n && t < 40) begin step(); t++; end
    if (acc_count < n) chk({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 40) begin step(); t++; end
    if (sb.size() != 0) chk({name, "_resp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_resp_valid(input int r, input string name);
    int t = 0;
    @(negedge clk);
    while (!resp_valid[r] && t < 20) begin @(negedge clk); t++; end
    if (!resp_valid[r]) chk({name, "_resp_valid_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input exp_t e);
    exp_next[r]          = e;
    req_op[3*r +: 3]     = op;
    req_a[DW*r +: DW]    = a;
    req_b[DW*r +: DW]    = b;
  endtask

  task automatic issue(input int r, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input exp_t e);
    set_req(r, op, a, b, e);
    req_valid[r] = 1'b1;
    wait_acc(acc_count + 1, $sformatf("t%0d", e.tag));
    req_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;
    step(); step();
    rst_n = 1'b1;
    sb.delete(); grant_log.delete(); acc_cyc.delete();
    step();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({name, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({name, "_resp_result"}, 64'(resp_result), 64'd0);
    chk({name, "_resp_zero"}, 64'(resp_zero), 64'd0);
    chk({name, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({name, "_alu_op"}, 64'(alu_op), 64'd0);
    chk({name, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({name, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
`ifdef ALU_ARB_OVF_EN
    chk({name, "_resp_ovf"}, 64'(resp_ovf), 64'd0);
`endif
  endtask

  vec_t tv[13];

  initial begin
    int base;
    tv[0]  = '{OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
    tv[1]  = '{OP_SUB, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1'b0};
    tv[2]  = '{OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
    tv[3]  = '{OP_ILL, 32'd3,          32'd4,          32'd0,          1'b1, 1'b1, 1'b0};
    tv[4]  = '{OP_AND, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0, 1'b0};
    tv[5]  = '{OP_OR,  32'h0000_F000,  32'h0000_000F,  32'h0000_F00F,  1'b0, 1'b0, 1'b0};
    tv[6]  = '{OP_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
    tv[7]  = '{OP_XOR, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0, 1'b0, 1'b0};
    tv[8]  = '{OP_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0, 1'b1};
    tv[9]  = '{OP_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
    tv[10] = '{OP_AND, 32'hFFFF_FFFF,  32'd0,          32'd0,          1'b1, 1'b0, 1'b0};
    tv[11] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
    tv[12] = '{OP_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; req_valid = '0; resp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    step(); step();
    @(negedge clk);
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // Table: one requester at a time, consumer always ready.
    resp_ready = '1;
    for (int i = 0; i < 13; i++) begin
      issue(i % 2, tv[i].op, tv[i].a, tv[i].b, mk(i, tv[i].res, tv[i].zero, tv[i].err, tv[i].ovf));
      wait_drain($sformatf("vec%0d", i));
      if (i == 0 && acc_cyc.size() > 0)
        chk("latency_accept_to_resp", 64'(resp_cyc - acc_cyc[acc_cyc.size()-1]), 64'd2);
      @(negedge clk);
      chk($sformatf("vec%0d_idle_after", i), 64'(busy), 64'd0);
      step();
    end

    // Back-to-back from one held requester: accepts exactly 3 cycles apart.
    acc_cyc.delete();
    base = acc_count;
    set_req(0, OP_ADD, 32'd1, 32'd2, mk(20, 32'd3, 1'b0, 1'b0, 1'b0));
    req_valid[0] = 1'b1;
    wait_acc(base + 3, "b2b");
    req_valid = '0;
    wait_drain("b2b");
    chk("b2b_count", 64'(acc_cyc.size()), 64'd3);
    if (acc_cyc.size() >= 3) begin
      chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
      chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    end

    // Fairness: both held after reset -> 0,1,0,1.
    do_reset();
    resp_ready = '1;
    base = acc_count;
    set_req(0, OP_ADD, 32'd2, 32'd3, mk(30, 32'd5, 1'b0, 1'b0, 1'b0));
    set_req(1, OP_SUB, 32'd10, 32'd4, mk(31, 32'd6, 1'b0, 1'b0, 1'b0));
    req_valid = 2'b11;
    wait_acc(base + 4, "rr4");
    req_valid = '0;
    wait_drain("rr4");
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_grant%0d", k), 64'(grant_log.size() > k ? grant_log[k] : -1), 64'(k % 2));

    // After reset: req1 alone, then both -> 1 then 0.
    do_reset();
    resp_ready = '1;
    base = acc_count;
    req_valid = 2'b10;
    wait_acc(base + 1, "rr_first");
    req_valid = 2'b11;
    wait_acc(base + 2, "rr_second");
    req_valid = '0;
    wait_drain("rr_pair");
    chk("rr_pair_grant0", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd1);
    chk("rr_pair_grant1", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'd0);

    // Backpressure: result held 5 cycles, waiting req1 accepted only after the handshake.
    resp_ready = '0;
    issue(0, OP_XOR, 32'hFF, 32'h0F, mk(40, 32'hF0, 1'b0, 1'b0, 1'b0));
    set_req(1, OP_OR, 32'd1, 32'd2, mk(41, 32'd3, 1'b0, 1'b0, 1'b0));
    req_valid[1] = 1'b1;
    wait_resp_valid(0, "bp");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_valid", k), 64'(resp_valid), 64'b01);
      chk($sformatf("bp_hold%0d_result", k), 64'(resp_result), 64'hF0);
      chk($sformatf("bp_hold%0d_no_accept", k), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    step();
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_no_accept_in_handshake", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("bp_accept_after_handshake", 64'(req_ready), 64'b10);
    step();
    req_valid = '0;
    resp_ready = '1;
    wait_drain("bp");

    // Reset mid-RESP with rr_ptr moved off 0.
    issue(0, OP_ADD, 32'd0, 32'd0, mk(50, 32'd0, 1'b1, 1'b0, 1'b0));
    wait_drain("pre_rst");
    resp_ready = '0;
    issue(1, OP_SUB, 32'd5, 32'd3, mk(51, 32'd2, 1'b0, 1'b0, 1'b0));
    wait_resp_valid(1, "mid_rst");
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    step();
    rst_n = 1'b1;
    sb.delete();
    resp_ready = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_resp_valid", k), 64'(resp_valid), 64'd0);
      chk($sformatf("post_rst%0d_busy", k), 64'(busy), 64'd0);
    end
    step();
    grant_log.delete();
    base = acc_count;
    set_req(0, OP_AND, 32'hF, 32'h3, mk(60, 32'h3, 1'b0, 1'b0, 1'b0));
    set_req(1, OP_OR, 32'h8, 32'h1, mk(61, 32'h9, 1'b0, 1'b0, 1'b0));
    req_valid = 2'b11;
    wait_acc(base + 1, "post_rst");
    req_valid = '0;
    wait_drain("post_rst");
    chk("post_rst_rr_ptr_zero", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
